std_mem_copy: RTL and testbench
===============================

Name: std_mem_copy

Overview:
Memory copy engine that acts as the initiator on a single std_mem_intf port. It drives the command stream and consumes the result stream of a memory responder such as one port of a single-cycle block-RAM wrapper. Given a source address, destination address and word count, it reads each source word, buffers it, and writes it to the destination in ascending order. It then pulses done. It sits beside a CPU or loader as a simple block-move or initialisation DMA.

Parameters:
BUFFER_DEPTH, 4, read-data buffer entries; power of two, at least 2; bounds outstanding reads plus buffered words.
MANUAL_ADDR_WIDTH, 0, nonzero overrides the address width taken from $bits(command.addr).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start_valid  in  1  copy request valid
start_ready  out  1  engine idle, request accepted on valid&&ready
start_src  in  ADDR_WIDTH  first source word address
start_dst  in  ADDR_WIDTH  first destination word address
start_length  in  ADDR_WIDTH+1  word count, 0 to 2**ADDR_WIDTH
busy  out  1  copy in progress (state RUN or DONE)
done  out  1  one-cycle pulse when the last write handshakes
command  std_mem_intf.out  -  valid/ready/read_enable/write_enable/addr/data toward memory
result  std_mem_intf.in  -  read data returning from memory; only data, valid and ready are used

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. Every flop clears on rst assertion, not on a clock edge.
- Reset values: state=IDLE, command.valid=0, command.read_enable=0, command.write_enable=0, command.addr=0, command.data=0, done=0, busy=0, buffer empty, all counters 0. start_ready=1 once reset is released. result.ready=1.
- Reset mid-copy: the transfer is abandoned immediately and command.valid drops asynchronously. No completion is signalled. Memory contents are whatever writes had already completed.
- States:
  - IDLE: start_ready=1. On start handshake, latch src, dst and length, and clear rd_idx, wr_idx, outstanding and buffer. If length==0 go to DONE, otherwise go to RUN.
  - RUN: issue commands. When wr_idx reaches length on a write handshake, go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Command output stage is registered. Once command.valid=1, addr, data, read_enable and write_enable hold stable until command.ready. A new command may load in the same cycle as a handshake, giving full throughput.
- Command selection when loading a new command (write has priority):
  - Write: buffer non-empty and wr_idx<length. write_enable=1, read_enable=0, addr=dst+wr_idx, data=buffer head; pop the buffer on load.
  - Read: rd_idx<length and outstanding+count<BUFFER_DEPTH. read_enable=1, write_enable=0, addr=src+rd_idx, data=0.
  - Credit: outstanding counts read commands that have been loaded but whose results have not yet returned. count is the buffer occupancy.
  - Otherwise command.valid=0.
- Results:
  - result.ready is tied to 1, because credit guarantees space.
  - Each result.valid pushes result.data into the buffer and decrements outstanding.
  - A push and a pop in the same cycle are both honoured.
- Arithmetic:
  - Addresses wrap modulo 2**ADDR_WIDTH, so src+idx is truncated.
  - Indices and length are ADDR_WIDTH+1 bits.
  - Overlapping regions with dst>src are unsupported; the resulting data is undefined. All other overlaps copy correctly.
- Latency:
  - Zero-length request: done is high in the cycle after the start handshake.
  - Minimum for N words against a single-cycle memory with ready always high: about 2N+2 cycles.
- start inputs are ignored outside IDLE.
- Exactly one done pulse per accepted request.

Decomposition:
- Package std_mem_copy_pkg holds:
  - std_mem_copy_state_t (IDLE, RUN, DONE);
  - the command-kind enum (CMD_NONE, CMD_READ, CMD_WRITE).
- Sub-module std_mem_copy_buffer is a BUFFER_DEPTH x DATA_WIDTH synchronous FIFO with push, pop, head and count. It uses the same asynchronous reset and is instantiated once.
- DATA_WIDTH is derived from $bits(command.data). Use the team's interface match macro to check command against result.

Test Plan:
- Ready always high, ADDR_WIDTH=8, src=0x10, dst=0x40, length=8, mem[0x10+i]=0xA0+i -> mem[0x40+i]=0xA0+i for i=0..7; exactly 8 reads and 8 writes; one done pulse; busy low after done.
- Same copy with command.ready randomly 50% -> command fields never change while valid&&!ready; identical final memory; outstanding+count never exceeds 4.
- Responder with 3-cycle read latency, length=16, BUFFER_DEPTH=4 -> never more than 4 reads in flight; all 16 words are correct.
- length=0 -> no command.valid ever asserted; done high in the cycle after the start handshake.
- src=0xFE, dst=0x02, length=4 -> reads 0xFE, 0xFF, 0x00, 0x01, then writes 0x02..0x05 with that data.
- Assert rst after the 3rd write of a 10-word copy -> command.valid=0 with no clock edge; done never pulses; start_ready=1 after release; a new length=2 copy completes correctly.

Source files
------------

// File: rtl/std_mem_copy_pkg.sv
// Shared state and command-kind types for the std_mem_copy block-move engine.
package std_mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } std_mem_copy_state_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } std_mem_copy_cmd_t;

endpackage

// File: rtl/std_mem_copy_if.sv
// Memory command/result stream: valid/ready handshake carrying read/write enables, address and data.
interface std_mem_intf #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic                  read_enable;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  // out: the side that produces the stream; in: the side that consumes it
  modport out (
    output valid, read_enable, write_enable, addr, data,
    input  ready
  );

  modport in (
    input  valid, read_enable, write_enable, addr, data,
    output ready
  );
endinterface

// File: rtl/std_mem_copy_buffer.sv
// Read-data FIFO for the copy engine: push/pop same cycle, head visible combinationally.
// No full/empty protection; the caller's credit scheme guarantees space and never pops empty.
module std_mem_copy_buffer #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/std_mem_copy.sv
// Memory copy initiator: reads src..src+len-1 and writes dst..dst+len-1, then pulses done (~2N+2 cycles).
// Registered command stage holds while command.ready is low; reads are credit-limited by BUFFER_DEPTH.
`ifndef STD_MEM_INTF_MATCH
`define STD_MEM_INTF_MATCH(a, b) if (($bits(a.data) != $bits(b.data)) || ($bits(a.addr) != $bits(b.addr))) begin : g_intf_mismatch $error("std_mem_intf width mismatch between command and result streams"); end
`endif

module std_mem_copy
  import std_mem_copy_pkg::*;
#(
  parameter int BUFFER_DEPTH      = 4,
  parameter int MANUAL_ADDR_WIDTH = 0
) (
  input  logic clk,
  input  logic rst,
  std_mem_intf.out command,
  std_mem_intf.in  result,
  input  logic start_valid,
  output logic start_ready,
  input  logic [((MANUAL_ADDR_WIDTH != 0) ? MANUAL_ADDR_WIDTH : $bits(command.addr))-1:0] start_src,
  input  logic [((MANUAL_ADDR_WIDTH != 0) ? MANUAL_ADDR_WIDTH : $bits(command.addr))-1:0] start_dst,
  input  logic [((MANUAL_ADDR_WIDTH != 0) ? MANUAL_ADDR_WIDTH : $bits(command.addr)):0]   start_length,
  output logic busy,
  output logic done
);

  localparam int AW  = (MANUAL_ADDR_WIDTH != 0) ? MANUAL_ADDR_WIDTH : $bits(command.addr);
  localparam int CAW = $bits(command.addr);
  localparam int DW  = $bits(command.data);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(BUFFER_DEPTH) + 1;

  `STD_MEM_INTF_MATCH(command, result)

  std_mem_copy_state_t state_q, state_d;
  logic [AW-1:0]       src_q, src_d;
  logic [AW-1:0]       dst_q, dst_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       rd_idx_q, rd_idx_d;
  logic [LW-1:0]       wr_idx_q, wr_idx_d;
  logic [CW-1:0]       outst_q, outst_d;

  logic                cmd_vld_q, cmd_vld_d;
  logic                cmd_re_q, cmd_re_d;
  logic                cmd_we_q, cmd_we_d;
  logic [AW-1:0]       cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]       cmd_data_q, cmd_data_d;

  std_mem_copy_cmd_t   cmd_sel;
  logic                cmd_fire;
  logic                can_load;
  logic                rsp_push;
  logic                buf_pop;
  logic                buf_clr;
  logic [CW-1:0]       buf_count;
  logic [DW-1:0]       buf_head;
  logic                unused_rsp;

  assign cmd_fire = cmd_vld_q && command.ready;
  assign can_load = !cmd_vld_q || command.ready;
  // Credit reserves buffer space for every read in flight, so results never need to stall.
  assign rsp_push = result.valid;

  std_mem_copy_buffer #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (DW)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .clr      (buf_clr),
    .push     (rsp_push),
    .push_dat (result.data),
    .pop      (buf_pop),
    .head_dat (buf_head),
    .count    (buf_count)
  );

  always_comb begin
    cmd_sel = CMD_NONE;
    if (state_q == RUN) begin
      if ((buf_count != '0) && (wr_idx_q < len_q)) begin
        cmd_sel = CMD_WRITE;
      end else if ((rd_idx_q < len_q) && ((outst_q + buf_count) < CW'(BUFFER_DEPTH))) begin
        cmd_sel = CMD_READ;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    outst_d    = outst_q - CW'(rsp_push);
    cmd_vld_d  = cmd_vld_q;
    cmd_re_d   = cmd_re_q;
    cmd_we_d   = cmd_we_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    buf_pop    = 1'b0;
    buf_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          src_d    = start_src;
          dst_d    = start_dst;
          len_d    = start_length;
          rd_idx_d = '0;
          wr_idx_d = '0;
          outst_d  = '0;
          buf_clr  = 1'b1;
          state_d  = (start_length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // wr_idx advances at load, so it already equals len while the final write waits
        if (cmd_fire && cmd_we_q && (wr_idx_q == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (can_load) begin
      cmd_vld_d = (cmd_sel != CMD_NONE);
      case (cmd_sel)
        CMD_WRITE: begin
          cmd_re_d   = 1'b0;
          cmd_we_d   = 1'b1;
          cmd_addr_d = dst_q + wr_idx_q[AW-1:0];
          cmd_data_d = buf_head;
          buf_pop    = 1'b1;
          wr_idx_d   = wr_idx_q + LW'(1);
        end
        CMD_READ: begin
          cmd_re_d   = 1'b1;
          cmd_we_d   = 1'b0;
          cmd_addr_d = src_q + rd_idx_q[AW-1:0];
          cmd_data_d = '0;
          rd_idx_d   = rd_idx_q + LW'(1);
          outst_d    = outst_d + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      outst_q    <= '0;
      cmd_vld_q  <= 1'b0;
      cmd_re_q   <= 1'b0;
      cmd_we_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      outst_q    <= outst_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_re_q   <= cmd_re_d;
      cmd_we_q   <= cmd_we_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  assign command.valid        = cmd_vld_q;
  assign command.read_enable  = cmd_re_q;
  assign command.write_enable = cmd_we_q;
  assign command.addr         = CAW'(cmd_addr_q);
  assign command.data         = cmd_data_q;

  assign result.ready = 1'b1;
  assign unused_rsp   = ^{result.read_enable, result.write_enable, result.addr};

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_std_mem_copy.sv
// Directed bench for std_mem_copy against a behavioural memory with configurable read latency and ready.
`timescale 1ns/1ps
module tb_std_mem_copy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  std_mem_intf #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) cmd_if ();
  std_mem_intf #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) rsp_if ();

  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] start_src = '0;
  logic [7:0] start_dst = '0;
  logic [8:0] start_length = '0;
  logic       busy;
  logic       done;

  std_mem_copy #(
    .BUFFER_DEPTH      (4),
    .MANUAL_ADDR_WIDTH (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .command      (cmd_if),
    .result       (rsp_if),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_src    (start_src),
    .start_dst    (start_dst),
    .start_length (start_length),
    .busy         (busy),
    .done         (done)
  );

  assign rsp_if.read_enable  = 1'b0;
  assign rsp_if.write_enable = 1'b0;
  assign rsp_if.addr         = 8'h00;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem [256];
  int         lat = 1;
  bit         rdy_rand = 1'b0;
  bit         pend_v [4];
  logic [7:0] pend_d [4];
  int         cnt_r, cnt_w, done_cnt, valid_seen, hold_viol, max_credit, max_inflight;
  logic [7:0] rd_log [$];
  bit         hold_prev;
  logic [7:0] prev_addr, prev_data;
  logic       prev_re, prev_we;

  initial cmd_if.ready = 1'b1;
  always @(negedge clk) cmd_if.ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

  // Memory responder and protocol monitor, evaluated on pre-edge values.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pend_v[i] = 1'b0;
      rsp_if.valid <= 1'b0;
      rsp_if.data  <= 8'h00;
      hold_prev = 1'b0;
    end else begin
      int credit;
      int infl;
      credit = cnt_r - cnt_w + ((cmd_if.valid && cmd_if.read_enable) ? 1 : 0)
                             - ((cmd_if.valid && cmd_if.write_enable) ? 1 : 0);
      if (credit > max_credit) max_credit = credit;
      if (hold_prev && (cmd_if.valid !== 1'b1 || cmd_if.addr !== prev_addr || cmd_if.data !== prev_data ||
                        cmd_if.read_enable !== prev_re || cmd_if.write_enable !== prev_we))
        hold_viol++;
      hold_prev = cmd_if.valid && !cmd_if.ready;
      prev_addr = cmd_if.addr;
      prev_data = cmd_if.data;
      prev_re   = cmd_if.read_enable;
      prev_we   = cmd_if.write_enable;
      if (cmd_if.valid) valid_seen++;
      if (done) done_cnt++;
      for (int i = 0; i < 3; i++) begin
        pend_v[i] = pend_v[i+1];
        pend_d[i] = pend_d[i+1];
      end
      pend_v[3] = 1'b0;
      if (cmd_if.valid && cmd_if.ready) begin
        if (cmd_if.write_enable) begin
          mem[cmd_if.addr] = cmd_if.data;
          cnt_w++;
        end
        if (cmd_if.read_enable) begin
          pend_v[lat-1] = 1'b1;
          pend_d[lat-1] = mem[cmd_if.addr];
          cnt_r++;
          rd_log.push_back(cmd_if.addr);
        end
      end
      infl = 0;
      for (int i = 0; i < 4; i++) infl += pend_v[i] ? 1 : 0;
      if (infl > max_inflight) max_inflight = infl;
      rsp_if.valid <= pend_v[0];
      rsp_if.data  <= pend_d[0];
    end
  end

  task automatic clear_stats();
    cnt_r = 0; cnt_w = 0; done_cnt = 0; valid_seen = 0;
    hold_viol = 0; max_credit = 0; max_inflight = 0;
    rd_log.delete();
  endtask

  task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
    @(negedge clk);
    start_src = s; start_dst = d; start_length = n; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (cmd_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: valid=%b busy=%b done=%b required 0 0 0", cmd_if.valid, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_start_ready: got %b required 1", start_ready);
    end
    vectors++;
    if ({cmd_if.valid, cmd_if.read_enable, cmd_if.write_enable} !== 3'b000) begin
      errors++;
      $display("FAIL reset_cmd_ctl: got %b required 000", {cmd_if.valid, cmd_if.read_enable, cmd_if.write_enable});
    end
    vectors++;
    if (cmd_if.addr !== 8'h00 || cmd_if.data !== 8'h00) begin
      errors++;
      $display("FAIL reset_cmd_bus: addr=%h data=%h required 00 00", cmd_if.addr, cmd_if.data);
    end
    vectors++;
    if (rsp_if.ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: rsp_ready=%b busy=%b done=%b required 1 0 0", rsp_if.ready, busy, done);
    end
  endtask

  task automatic test_basic(input bit random_ready);
    bit ok;
    logic [7:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 8'(8'h10 + i); mem[a] = 8'(8'hA0 + i);
      a = 8'(8'h40 + i); mem[a] = 8'h00;
    end
    clear_stats();
    rdy_rand = random_ready;
    start_copy(8'h10, 8'h40, 9'd8);
    wait_done(300, ok);
    rdy_rand = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL copy8_done(rr=%0d): no done within budget, required one pulse", random_ready);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL copy8_busy_after(rr=%0d): got %b required 0", random_ready, busy);
    end
    for (int i = 0; i < 8; i++) begin
      a = 8'(8'h40 + i);
      vectors++;
      if (mem[a] !== 8'(8'hA0 + i)) begin
        errors++;
        $display("FAIL copy8_data(rr=%0d)[%0d]: got %h required %h", random_ready, i, mem[a], 8'(8'hA0 + i));
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (cnt_r != 8 || cnt_w != 8 || done_cnt != 1) begin
      errors++;
      $display("FAIL copy8_counts(rr=%0d): reads=%0d writes=%0d dones=%0d required 8 8 1", random_ready, cnt_r, cnt_w, done_cnt);
    end
    vectors++;
    if (hold_viol != 0 || max_credit > 4) begin
      errors++;
      $display("FAIL copy8_hold_credit(rr=%0d): hold_viol=%0d max_credit=%0d required 0 and <=4", random_ready, hold_viol, max_credit);
    end
  endtask

  task automatic test_latency();
    bit ok;
    logic [7:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 8'(8'h80 + i); mem[a] = 8'(8'h30 + i);
      a = 8'(8'hC0 + i); mem[a] = 8'h00;
    end
    clear_stats();
    lat = 3;
    start_copy(8'h80, 8'hC0, 9'd16);
    wait_done(500, ok);
    repeat (2) @(negedge clk);
    lat = 1;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL lat3_done: no done within budget, required one pulse");
    end
    vectors++;
    if (max_inflight > 4 || max_credit > 4) begin
      errors++;
      $display("FAIL lat3_inflight: inflight=%0d credit=%0d required <=4", max_inflight, max_credit);
    end
    for (int i = 0; i < 16; i++) begin
      a = 8'(8'hC0 + i);
      vectors++;
      if (mem[a] !== 8'(8'h30 + i)) begin
        errors++;
        $display("FAIL lat3_data[%0d]: got %h required %h", i, mem[a], 8'(8'h30 + i));
      end
    end
  endtask

  task automatic test_zero_len();
    clear_stats();
    start_copy(8'h00, 8'h00, 9'd0);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done_next: done=%b busy=%b required 1 1", done, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_after: done=%b busy=%b start_ready=%b required 0 0 1", done, busy, start_ready);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (valid_seen != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_cmds: valid_cycles=%0d dones=%0d required 0 1", valid_seen, done_cnt);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] exp_addr [4];
    logic [7:0] exp_dat [4];
    logic [7:0] a;
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_dat  = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      mem[exp_addr[i]] = exp_dat[i];
      a = 8'(8'h02 + i); mem[a] = 8'h00;
    end
    clear_stats();
    start_copy(8'hFE, 8'h02, 9'd4);
    wait_done(200, ok);
    vectors++;
    if (!ok || rd_log.size() != 4) begin
      errors++;
      $display("FAIL wrap_reads: done=%0d reads=%0d required 1 4", ok, rd_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= rd_log.size() || rd_log[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_rd_addr[%0d]: got %h required %h", i, (i < rd_log.size()) ? rd_log[i] : 8'hxx, exp_addr[i]);
      end
      a = 8'(8'h02 + i);
      vectors++;
      if (mem[a] !== exp_dat[i]) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %h required %h", i, mem[a], exp_dat[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] a;
    for (int i = 0; i < 10; i++) begin
      a = 8'(8'h10 + i); mem[a] = 8'(8'hA0 + i);
      a = 8'(8'h60 + i); mem[a] = 8'h00;
    end
    mem[8'h70] = 8'h00;
    mem[8'h71] = 8'h00;
    clear_stats();
    start_copy(8'h10, 8'h60, 9'd10);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cnt_w >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok || cnt_w != 3) begin
      errors++;
      $display("FAIL rstmid_third_write: reached=%0d writes=%0d required 1 3", ok, cnt_w);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (cmd_if.valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b busy=%b required 0 0", cmd_if.valid, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (start_ready !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL rstmid_release: start_ready=%b dones=%0d required 1 0", start_ready, done_cnt);
    end
    vectors++;
    if (mem[8'h62] !== 8'hA2 || mem[8'h63] !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_partial: mem62=%h mem63=%h required a2 00", mem[8'h62], mem[8'h63]);
    end
    clear_stats();
    start_copy(8'h10, 8'h70, 9'd2);
    wait_done(200, ok);
    repeat (2) @(negedge clk);
    vectors++;
    if (!ok || done_cnt != 1 || cnt_w != 2) begin
      errors++;
      $display("FAIL rstmid_recopy: done=%0d dones=%0d writes=%0d required 1 1 2", ok, done_cnt, cnt_w);
    end
    vectors++;
    if (mem[8'h70] !== 8'hA0 || mem[8'h71] !== 8'hA1) begin
      errors++;
      $display("FAIL rstmid_recopy_data: got %h %h required a0 a1", mem[8'h70], mem[8'h71]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = 8'h00;
    end
    clear_stats();
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_latency();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
